// File: rtl/red_pitaya_daisy_deser.sv
`timescale 1ns/1ps
// Daisy-chain word receiver: turns a bit-strobed serial stream into DW-bit words.
// Alignment is found by searching for the training word. Once locked, non-idle
// words are delivered on a one-cycle valid/data port and counted.
module red_pitaya_daisy_deser #(
  parameter int             DW        = 16,
  parameter logic [DW-1:0]  TRAIN_PAT = 16'h00FF,
  parameter int             LOCK_CNT  = 4
) (
  input  logic          par_clk_i,
  input  logic          par_rst_i,
  input  logic          ser_bit_en_i,
  input  logic          ser_dat_i,
  input  logic          cfg_en_i,
  input  logic          cfg_train_i,
  output logic          cfg_trained_o,
  output logic          par_dv_o,
  output logic [DW-1:0] par_dat_o,
  output logic [31:0]   stat_wrd_o,
  output logic [31:0]   stat_err_o
);

  localparam int CW = $clog2(DW);
  localparam int MW = $clog2(LOCK_CNT + 1);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_SEARCH,
    ST_LOCKED
  } state_t;

  state_t state;
  state_t state_nxt;

  // Only DW-1 history bits are stored; the incoming bit completes the word.
  logic [DW-2:0] sr;
  logic [CW-1:0] bit_cnt;
  logic [MW-1:0] match_cnt;
  logic          train_q;

  logic [DW-1:0] nxt;
  logic          boundary;
  logic          word_is_train;
  logic          train_rise;
  logic          search_hit;
  logic [MW-1:0] match_next;

  assign nxt           = {sr, ser_dat_i};
  assign boundary      = ser_bit_en_i && (bit_cnt == CW'(DW - 1));
  assign word_is_train = (nxt == TRAIN_PAT);
  assign train_rise    = cfg_train_i && !train_q;
  // Before the first hit every bit position is a candidate; afterwards only word boundaries.
  assign search_hit    = ser_bit_en_i && word_is_train && ((match_cnt == '0) || boundary);
  assign match_next    = match_cnt + MW'(1);

  // State register.
  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      state <= ST_DISABLED;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decision; losing the enable overrides everything else.
  always_comb begin
    state_nxt = state;
    if (!cfg_en_i) begin
      state_nxt = ST_DISABLED;
    end else begin
      case (state)
        ST_DISABLED: if (cfg_train_i) state_nxt = ST_SEARCH;
        ST_SEARCH:   if (search_hit && (match_next == MW'(LOCK_CNT))) state_nxt = ST_LOCKED;
        ST_LOCKED:   if (train_rise) state_nxt = ST_SEARCH;
        default:     state_nxt = ST_DISABLED;
      endcase
    end
  end

  // Lock indication is a pure decode of the state.
  always_comb begin
    cfg_trained_o = (state == ST_LOCKED);
  end

  // Edge detector history for the training request.
  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      train_q <= 1'b0;
    end else begin
      train_q <= cfg_train_i;
    end
  end

  // Shift register, bit position and training-match counter.
  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      sr        <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
    end else if (!cfg_en_i || (state == ST_DISABLED)) begin
      sr        <= '0;
      bit_cnt   <= '0;
      match_cnt <= '0;
    end else begin
      if (ser_bit_en_i) begin
        sr      <= nxt[DW-2:0];
        bit_cnt <= (bit_cnt == CW'(DW - 1)) ? '0 : bit_cnt + CW'(1);
      end
      if ((state == ST_SEARCH) && ser_bit_en_i) begin
        if (match_cnt == '0) begin
          if (word_is_train) begin
            bit_cnt   <= '0;
            match_cnt <= MW'(1);
          end
        end else if (boundary) begin
          match_cnt <= word_is_train ? match_next : '0;
        end
      end
      if ((state == ST_LOCKED) && train_rise) begin
        match_cnt <= '0;
      end
    end
  end

  // Word delivery and link statistics while locked; statistics survive disable.
  always_ff @(posedge par_clk_i or posedge par_rst_i) begin
    if (par_rst_i) begin
      par_dv_o   <= 1'b0;
      par_dat_o  <= '0;
      stat_wrd_o <= '0;
      stat_err_o <= '0;
    end else begin
      par_dv_o <= 1'b0;
      if (cfg_en_i && (state == ST_LOCKED) && boundary) begin
        if (nxt != '0) begin
          par_dv_o   <= 1'b1;
          par_dat_o  <= nxt;
          stat_wrd_o <= stat_wrd_o + 32'd1;
        end
        if (cfg_train_i && !word_is_train && (stat_err_o != '1)) begin
          stat_err_o <= stat_err_o + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_red_pitaya_daisy_deser.sv
`timescale 1ns/1ps
// Directed bench for the daisy-chain word receiver: lock, delivery, error
// statistics with saturation, relock after disable and asynchronous reset.
module tb_red_pitaya_daisy_deser;

  logic        clock = 1'b0;
  logic        rst = 1'b1;
  logic        bit_en = 1'b0;
  logic        ser_dat = 1'b0;
  logic        en = 1'b0;
  logic        train = 1'b0;
  logic        trained;
  logic        dv;
  logic [15:0] dat;
  logic [31:0] stat_wrd;
  logic [31:0] stat_err;

  int compare_count = 0;
  int fail_count = 0;
  int dv_pulses = 0;
  int dv_snap = 0;

  red_pitaya_daisy_deser dut (
    .par_clk_i     (clock),
    .par_rst_i     (rst),
    .ser_bit_en_i  (bit_en),
    .ser_dat_i     (ser_dat),
    .cfg_en_i      (en),
    .cfg_train_i   (train),
    .cfg_trained_o (trained),
    .par_dv_o      (dv),
    .par_dat_o     (dat),
    .stat_wrd_o    (stat_wrd),
    .stat_err_o    (stat_err)
  );

  // Free-running 100 MHz clock.
  always #5 clock = ~clock;

  // Count every valid pulse so delivery during search can be detected.
  always @(negedge clock) begin
    if (dv === 1'b1) dv_pulses++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compare_count++;
    assert (obs === exp) else begin
      fail_count++;
      $error("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic applyBit(input logic b);
    @(negedge clock);
    bit_en  = 1'b1;
    ser_dat = b;
  endtask

  // Sends one word MSB first at one bit per clock, then idles one cycle so the
  // result of the last bit is visible on return.
  task automatic applyStimulus(input logic [15:0] w);
    for (int i = 15; i >= 0; i--) applyBit(w[i]);
    @(negedge clock);
    bit_en  = 1'b0;
    ser_dat = 1'b0;
  endtask

  // Linear directed sequence.
  initial begin
    logic [15:0] w5;
    logic [7:0]  half;
    w5   = 16'h1111;
    half = 8'hAA;

    repeat (2) @(negedge clock);
    checkOutput("reset_trained", {31'd0, trained}, 32'd0);
    checkOutput("reset_dv", {31'd0, dv}, 32'd0);
    checkOutput("reset_dat", {16'd0, dat}, 32'd0);
    checkOutput("reset_wrd", stat_wrd, 32'd0);
    checkOutput("reset_err", stat_err, 32'd0);
    rst = 1'b0;

    $display("[TB] step 1: initial lock");
    @(negedge clock);
    en    = 1'b1;
    train = 1'b1;
    @(negedge clock);
    applyBit(1'b1);
    applyBit(1'b0);
    applyBit(1'b1);
    applyStimulus(16'h00FF);
    applyStimulus(16'h00FF);
    applyStimulus(16'h00FF);
    checkOutput("t1_not_locked_after_3", {31'd0, trained}, 32'd0);
    applyStimulus(16'h00FF);
    checkOutput("t1_locked_after_4", {31'd0, trained}, 32'd1);
    checkOutput("t1_no_words_yet", stat_wrd, 32'd0);

    $display("[TB] step 4: error statistics with training held");
    applyStimulus(16'h00FF);
    checkOutput("t4_dv_train", {31'd0, dv}, 32'd1);
    checkOutput("t4_dat_train", {16'd0, dat}, 32'h000000FF);
    checkOutput("t4_err_zero", stat_err, 32'd0);
    applyStimulus(16'h0F0F);
    checkOutput("t4_dat_bad", {16'd0, dat}, 32'h00000F0F);
    checkOutput("t4_err_one", stat_err, 32'd1);
    applyStimulus(16'h00FF);
    checkOutput("t4_err_still_one", stat_err, 32'd1);
    checkOutput("t4_wrd_three", stat_wrd, 32'd3);
    force dut.stat_err_o = 32'hFFFFFFFF;
    @(negedge clock);
    release dut.stat_err_o;
    @(negedge clock);
    checkOutput("t4_err_forced", stat_err, 32'hFFFFFFFF);
    applyStimulus(16'h0F0F);
    checkOutput("t4_err_saturated", stat_err, 32'hFFFFFFFF);
    checkOutput("t4_wrd_four", stat_wrd, 32'd4);

    $display("[TB] step 2: delivery with idle word");
    train = 1'b0;
    @(negedge clock);
    applyStimulus(16'hA5C3);
    checkOutput("t2_dv_a5c3", {31'd0, dv}, 32'd1);
    checkOutput("t2_dat_a5c3", {16'd0, dat}, 32'h0000A5C3);
    @(negedge clock);
    checkOutput("t2_dv_single_cycle", {31'd0, dv}, 32'd0);
    applyStimulus(16'h0000);
    checkOutput("t2_dv_idle", {31'd0, dv}, 32'd0);
    checkOutput("t2_dat_held", {16'd0, dat}, 32'h0000A5C3);
    applyStimulus(16'h1234);
    checkOutput("t2_dv_1234", {31'd0, dv}, 32'd1);
    checkOutput("t2_dat_1234", {16'd0, dat}, 32'h00001234);
    checkOutput("t2_wrd_six", stat_wrd, 32'd6);
    checkOutput("t2_err_untouched", stat_err, 32'hFFFFFFFF);

    $display("[TB] step 3: retrain with a broken pattern");
    @(negedge clock);
    dv_snap = dv_pulses;
    train = 1'b1;
    @(negedge clock);
    checkOutput("t3_unlocked_on_rise", {31'd0, trained}, 32'd0);
    applyStimulus(16'h00FF);
    applyStimulus(16'h00FF);
    applyStimulus(16'h00FE);
    applyStimulus(16'h00FF);
    applyStimulus(16'h00FF);
    applyStimulus(16'h00FF);
    checkOutput("t3_not_locked_early", {31'd0, trained}, 32'd0);
    applyStimulus(16'h00FF);
    checkOutput("t3_locked", {31'd0, trained}, 32'd1);
    checkOutput("t3_no_dv_in_search", dv_pulses, dv_snap);
    checkOutput("t3_wrd_unchanged", stat_wrd, 32'd6);

    $display("[TB] step 5: disable on a boundary");
    dv_snap = dv_pulses;
    for (int i = 15; i >= 1; i--) applyBit(w5[i]);
    @(negedge clock);
    bit_en  = 1'b1;
    ser_dat = w5[0];
    en      = 1'b0;
    @(negedge clock);
    bit_en  = 1'b0;
    ser_dat = 1'b0;
    checkOutput("t5_no_dv", {31'd0, dv}, 32'd0);
    checkOutput("t5_unlocked", {31'd0, trained}, 32'd0);
    checkOutput("t5_wrd_kept", stat_wrd, 32'd6);
    checkOutput("t5_pulses_kept", dv_pulses, dv_snap);
    en = 1'b1;
    applyStimulus(16'h00FF);
    applyStimulus(16'h00FF);
    applyStimulus(16'h00FF);
    checkOutput("t5_not_relocked_early", {31'd0, trained}, 32'd0);
    applyStimulus(16'h00FF);
    checkOutput("t5_relocked", {31'd0, trained}, 32'd1);

    $display("[TB] step 6: asynchronous reset mid-word");
    for (int i = 7; i >= 0; i--) applyBit(half[i]);
    #2 rst = 1'b1;
    #1;
    checkOutput("t6_trained_cleared", {31'd0, trained}, 32'd0);
    checkOutput("t6_dv_cleared", {31'd0, dv}, 32'd0);
    checkOutput("t6_dat_cleared", {16'd0, dat}, 32'd0);
    checkOutput("t6_wrd_cleared", stat_wrd, 32'd0);
    checkOutput("t6_err_cleared", stat_err, 32'd0);
    bit_en = 1'b0;
    #1 rst = 1'b0;
    @(negedge clock);
    checkOutput("t6_still_unlocked", {31'd0, trained}, 32'd0);
    checkOutput("t6_wrd_still_zero", stat_wrd, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compare_count, fail_count);
    $finish;
  end

endmodule
